// File: rtl/mcpu_pkg.sv
// Shared definitions for the mcpu front end: fetch FSM states and
// instruction-format constants.
package mcpu_pkg;

   typedef enum logic [1:0] {
      S_OP  = 2'd0,
      S_IMM = 2'd1,
      S_OUT = 2'd2
   } fetch_state_e;

   localparam int INSTR_LEN_SHORT = 1;
   localparam int INSTR_LEN_LONG  = 4;
   localparam int IMM_FLAG_BIT    = 7;

endpackage

// File: rtl/mcpu_fetch.sv
// Instruction fetch: reads 1- or 4-byte instructions from a dual-port byte ROM
// and presents one decoded bundle at a time with a valid/ready handshake.
module mcpu_fetch #(
   parameter int                        IROM_ADDR_BITS = 14,
   parameter logic [IROM_ADDR_BITS-1:0] RESET_PC       = '0
) (
   input  logic                      clk,
   input  logic                      reset,
   output logic [IROM_ADDR_BITS-1:0] irom_addr0,
   input  logic [7:0]                irom_out0,
   output logic [IROM_ADDR_BITS-1:0] irom_addr1,
   input  logic [7:0]                irom_out1,
   input  logic                      fetch_en,
   input  logic                      branch_valid,
   input  logic [IROM_ADDR_BITS-1:0] branch_target,
   output logic                      instr_valid,
   input  logic                      instr_ready,
   output logic [7:0]                instr_opcode,
   output logic                      instr_has_imm,
   output logic [23:0]               instr_imm,
   output logic [IROM_ADDR_BITS-1:0] instr_pc
);
   import mcpu_pkg::*;

   localparam int AW = IROM_ADDR_BITS;

   fetch_state_e  state;
   logic [AW-1:0] pc;

   // Address sums truncate to AW bits, so fetches wrap around the ROM top.
   always_comb begin
      irom_addr0 = pc;
      irom_addr1 = pc + AW'(1);
      if (state == S_IMM) begin
         irom_addr0 = pc + AW'(2);
         irom_addr1 = pc + AW'(3);
      end
   end

   assign instr_valid   = (state == S_OUT);
   assign instr_has_imm = instr_opcode[IMM_FLAG_BIT];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= S_OP;
         pc           <= RESET_PC;
         instr_opcode <= '0;
         instr_imm    <= '0;
         instr_pc     <= '0;
      end else if (branch_valid) begin
         // Redirect wins over stalls and over a same-cycle handshake.
         pc    <= branch_target;
         state <= S_OP;
      end else begin
         case (state)
            S_OP: begin
               if (fetch_en) begin
                  instr_opcode <= irom_out0;
                  instr_pc     <= pc;
                  if (!irom_out0[IMM_FLAG_BIT]) begin
                     pc        <= pc + AW'(INSTR_LEN_SHORT);
                     instr_imm <= '0;
                     state     <= S_OUT;
                  end else begin
                     instr_imm <= {16'h0000, irom_out1};
                     state     <= S_IMM;
                  end
               end
            end
            S_IMM: begin
               if (fetch_en) begin
                  instr_imm[23:8] <= {irom_out1, irom_out0};
                  pc              <= pc + AW'(INSTR_LEN_LONG);
                  state           <= S_OUT;
               end
            end
            S_OUT: begin
               if (instr_ready) state <= S_OP;
            end
            default: state <= S_OP;
         endcase
      end
   end

endmodule

// File: tb/tb_mcpu_fetch.sv
// Bench for mcpu_fetch: behavioural ROM, table of single instructions plus
// hand sequences for stall, redirect and reset corners.
module tb_mcpu_fetch;

   localparam int AW = 14;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] irom_addr0, irom_addr1;
   logic [7:0]    irom_out0, irom_out1;
   logic          fetch_en, branch_valid, instr_valid, instr_ready, instr_has_imm;
   logic [AW-1:0] branch_target, instr_pc;
   logic [7:0]    instr_opcode;
   logic [23:0]   instr_imm;

   logic [7:0] rom [0:(1<<AW)-1];
   assign irom_out0 = rom[irom_addr0];
   assign irom_out1 = rom[irom_addr1];

   always #5 clk = ~clk;

   mcpu_fetch #(.IROM_ADDR_BITS(AW), .RESET_PC(14'h0000)) dut (
      .clk(clk), .reset(reset),
      .irom_addr0(irom_addr0), .irom_out0(irom_out0),
      .irom_addr1(irom_addr1), .irom_out1(irom_out1),
      .fetch_en(fetch_en), .branch_valid(branch_valid), .branch_target(branch_target),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_opcode(instr_opcode), .instr_has_imm(instr_has_imm),
      .instr_imm(instr_imm), .instr_pc(instr_pc)
   );

   typedef struct {
      logic [7:0]    op;
      logic [23:0]   imm;
      logic          has;
      logic [AW-1:0] pc;
   } bundle_t;

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   bytes;   // byte k at addr+k in bits [8k+7:8k]
      logic [7:0]    exp_op;
      logic [23:0]   exp_imm;
      logic          exp_has;
      logic [AW-1:0] exp_next;
      int            lat;
   } vec_t;

   bundle_t sb[$];
   vec_t    tbl[6];
   int      vectors = 0;
   int      miscompares = 0;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Waits (bounded) for a bundle, then compares it against the scoreboard head.
   task automatic wait_bundle(input int lat);
      bundle_t e;
      int n = 0;
      while (!instr_valid && n < 8) begin
         tick;
         n++;
      end
      check("bundle_arrives", 32'(instr_valid), 32'd1);
      if (lat > 0) check("latency", 32'(n), 32'(lat));
      check("scoreboard_nonempty", 32'(sb.size()), 32'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check("opcode",  32'(instr_opcode),  32'(e.op));
         check("imm",     32'(instr_imm),     32'(e.imm));
         check("has_imm", 32'(instr_has_imm), 32'(e.has));
         check("pc",      32'(instr_pc),      32'(e.pc));
      end
   endtask

   task automatic accept;
      instr_ready = 1'b1;
      tick;
      instr_ready = 1'b0;
      check("valid_after_accept", 32'(instr_valid), 32'd0);
   endtask

   task automatic redirect(input logic [AW-1:0] tgt);
      branch_target = tgt;
      branch_valid  = 1'b1;
      tick;
      branch_valid  = 1'b0;
      check("valid_after_branch", 32'(instr_valid), 32'd0);
   endtask

   task automatic run_vec(input vec_t v);
      logic [AW-1:0] a1;
      for (int k = 0; k < 4; k++) rom[AW'(v.addr + AW'(k))] = v.bytes[8*k +: 8];
      a1 = v.addr + AW'(1);
      redirect(v.addr);
      check("addr0_op", 32'(irom_addr0), 32'(v.addr));
      check("addr1_op", 32'(irom_addr1), 32'(a1));
      sb.push_back('{v.exp_op, v.exp_imm, v.exp_has, v.addr});
      wait_bundle(v.lat);
      check("next_pc", 32'(irom_addr0), 32'(v.exp_next));
      accept;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{14'h0010, 32'h07124781, 8'h81, 24'h071247, 1'b1, 14'h0014, 2};
      tbl[1] = '{14'h3FFE, 32'h3322119A, 8'h9A, 24'h332211, 1'b1, 14'h0002, 2};
      tbl[2] = '{14'h3FFF, 32'h5566777F, 8'h7F, 24'h000000, 1'b0, 14'h0000, 1};
      tbl[3] = '{14'h0100, 32'h00000080, 8'h80, 24'h000000, 1'b1, 14'h0104, 2};
      tbl[4] = '{14'h0200, 32'hAABBCCFF, 8'hFF, 24'hAABBCC, 1'b1, 14'h0204, 2};
      tbl[5] = '{14'h1234, 32'hFFFFFF00, 8'h00, 24'h000000, 1'b0, 14'h1235, 1};

      for (int i = 0; i < (1<<AW); i++) rom[i] = 8'h00;
      rom[0] = 8'h05;
      rom[1] = 8'h03;
      reset = 1'b1; fetch_en = 1'b0; branch_valid = 1'b0; instr_ready = 1'b0;
      branch_target = '0;
      repeat (2) tick;
      check("rst_valid",  32'(instr_valid),   32'd0);
      check("rst_opcode", 32'(instr_opcode),  32'd0);
      check("rst_imm",    32'(instr_imm),     32'd0);
      check("rst_has",    32'(instr_has_imm), 32'd0);
      check("rst_pc",     32'(instr_pc),      32'd0);
      check("rst_addr0",  32'(irom_addr0),    32'd0);

      // First fetch from reset, then a 5-cycle stall in S_OUT.
      reset = 1'b0; fetch_en = 1'b1;
      sb.push_back('{8'h05, 24'h0, 1'b0, 14'h0000});
      wait_bundle(1);
      for (int c = 0; c < 5; c++) begin
         tick;
         check("stall_valid",  32'(instr_valid),  32'd1);
         check("stall_opcode", 32'(instr_opcode), 32'h05);
         check("stall_pc",     32'(instr_pc),     32'd0);
      end
      accept;
      sb.push_back('{8'h03, 24'h0, 1'b0, 14'h0001});
      wait_bundle(1);
      accept;

      foreach (tbl[i]) run_vec(tbl[i]);

      // Redirect while a 4-byte instruction is half fetched.
      rom[14'h0010] = 8'h81; rom[14'h0011] = 8'h47; rom[14'h0012] = 8'h12; rom[14'h0013] = 8'h07;
      rom[14'h0200] = 8'h2A;
      redirect(14'h0010);
      tick;
      check("in_imm_addr0", 32'(irom_addr0), 32'h0012);
      redirect(14'h0200);
      sb.push_back('{8'h2A, 24'h0, 1'b0, 14'h0200});
      wait_bundle(1);

      // Redirect on the same edge as an accepted handshake.
      instr_ready = 1'b1;
      redirect(14'h0200);
      instr_ready = 1'b0;
      sb.push_back('{8'h2A, 24'h0, 1'b0, 14'h0200});
      wait_bundle(1);
      accept;

      // Redirect under fetch_en=0, then a stall in S_IMM.
      fetch_en = 1'b0;
      redirect(14'h0010);
      repeat (2) begin
         tick;
         check("halt_valid", 32'(instr_valid), 32'd0);
         check("halt_addr0", 32'(irom_addr0),  32'h0010);
      end
      fetch_en = 1'b1;
      tick;
      check("imm_addr0", 32'(irom_addr0), 32'h0012);
      check("imm_addr1", 32'(irom_addr1), 32'h0013);
      fetch_en = 1'b0;
      repeat (2) begin
         tick;
         check("imm_halt_valid", 32'(instr_valid), 32'd0);
         check("imm_halt_addr0", 32'(irom_addr0),  32'h0012);
      end
      sb.push_back('{8'h81, 24'h071247, 1'b1, 14'h0010});
      fetch_en = 1'b1;
      wait_bundle(1);
      check("long_next_pc", 32'(irom_addr0), 32'h0014);
      accept;

      // Reset pulse while in S_IMM, then held off with fetch_en=0.
      redirect(14'h0010);
      tick;
      check("pre_rst_addr0", 32'(irom_addr0), 32'h0012);
      reset = 1'b1;
      #1;
      check("mid_rst_valid",  32'(instr_valid),  32'd0);
      check("mid_rst_opcode", 32'(instr_opcode), 32'd0);
      check("mid_rst_imm",    32'(instr_imm),    32'd0);
      check("mid_rst_pc",     32'(instr_pc),     32'd0);
      check("mid_rst_addr0",  32'(irom_addr0),   32'd0);
      fetch_en = 1'b0;
      reset = 1'b0;
      rom[0] = 8'h05;
      repeat (3) begin
         tick;
         check("post_rst_valid",  32'(instr_valid),  32'd0);
         check("post_rst_opcode", 32'(instr_opcode), 32'd0);
      end
      sb.push_back('{8'h05, 24'h0, 1'b0, 14'h0000});
      fetch_en = 1'b1;
      wait_bundle(1);
      accept;

      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mcpu_fetch.md
MCPU_FETCH -- requirements
Module: mcpu_fetch

Interface
REQ-001 Parameter IROM_ADDR_BITS, default 14, SHALL set the instruction-ROM byte address width.
REQ-002 Parameter RESET_PC, default 0, SHALL set the program counter value loaded on reset.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  rising-edge system clock.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 irom_addr0  out  IROM_ADDR_BITS  IROM port-0 byte address.
REQ-007 irom_out0  in  8  IROM port-0 byte, combinational from irom_addr0.
REQ-008 irom_addr1  out  IROM_ADDR_BITS  IROM port-1 byte address.
REQ-009 irom_out1  in  8  IROM port-1 byte, combinational from irom_addr1.
REQ-010 fetch_en  in  1  fetch enable; low stalls fetching (halt/debug).
REQ-011 branch_valid  in  1  one-cycle redirect request.
REQ-012 branch_target  in  IROM_ADDR_BITS  redirect address.
REQ-013 instr_valid  out  1  instruction bundle valid to decoder.
REQ-014 instr_ready  in  1  decoder accepts bundle.
REQ-015 instr_opcode  out  8  opcode byte.
REQ-016 instr_has_imm  out  1  opcode[7]; bundle carries an immediate.
REQ-017 instr_imm  out  24  immediate, little-endian from bytes pc+1..pc+3; 0 when instr_has_imm=0.
REQ-018 instr_pc  out  IROM_ADDR_BITS  address of the opcode byte.

Function
REQ-019 Instruction format SHALL be: 1 opcode byte; if opcode[7]=1, followed by 3 immediate bytes (4 bytes total), else 1 byte total.
REQ-020 The FSM SHALL have states S_OP, S_IMM, S_OUT.
REQ-021 In S_OP, irom_addr0=pc and irom_addr1=pc+1; in S_IMM, irom_addr0=pc+2 and irom_addr1=pc+3; in S_OUT, addresses SHALL hold their S_OP values.
REQ-022 All address arithmetic SHALL wrap modulo 2^IROM_ADDR_BITS (pc=0x3FFF fetches byte 1 from 0x0000).
REQ-023 S_OP with fetch_en=1: capture opcode=irom_out0, instr_pc=pc; if irom_out0[7]=0, pc<=pc+1, imm<=0, go S_OUT; else imm[7:0]<=irom_out1, go S_IMM.
REQ-024 S_IMM with fetch_en=1: imm[15:8]<=irom_out0, imm[23:16]<=irom_out1, pc<=pc+4, go S_OUT.
REQ-025 fetch_en=0 in S_OP or S_IMM SHALL hold state, pc, and captured data; S_OUT is unaffected by fetch_en.
REQ-026 instr_valid SHALL be 1 exactly in S_OUT; bundle outputs SHALL be stable while instr_valid=1 and instr_ready=0.
REQ-027 In S_OUT with instr_ready=1, the bundle is consumed and the next state SHALL be S_OP.
REQ-028 Latency: 1-byte instruction valid 1 cycle after entering S_OP; 4-byte instruction valid 2 cycles after; peak throughput one instruction per 2 cycles.
REQ-029 branch_valid=1 in any state SHALL set pc<=branch_target and state<=S_OP, discarding any partial or offered bundle; instr_valid SHALL be 0 next cycle.
REQ-030 branch_valid SHALL take priority over fetch_en=0 and over a simultaneous instr_ready handshake; the handshake still counts as consumed by the decoder.

Reset
REQ-031 While reset=1: pc=RESET_PC, state=S_OP, instr_valid=0, instr_opcode=0, instr_imm=0, instr_has_imm=0, instr_pc=0.
REQ-032 Reset asserted mid-operation (S_IMM or S_OUT) SHALL discard all in-flight data; the first fetch after deassertion SHALL be from RESET_PC.

Structure
REQ-033 The FSM state encoding, instruction-length constants (1, 4), and immediate-flag bit index (7) SHALL live in shared package mcpu_pkg.
REQ-034 No sub-module is required; the FSM, pc register, and bundle registers SHALL reside in mcpu_fetch, which SHALL connect to mcpu_irom by port name.

Verification
REQ-035 ROM[0]=0x05, ready=1 -> after reset, bundle opcode=0x05, has_imm=0, imm=0, instr_pc=0x0000; next fetch at 0x0001.
REQ-036 ROM[0x10..0x13]=0x81,0x47,0x12,0x07, pc=0x10 -> opcode=0x81, imm=0x071247, instr_pc=0x0010, valid 2 cycles after S_OP entry; next pc=0x14.
REQ-037 4-byte instruction at 0x3FFE -> immediate bytes read from 0x3FFF, 0x0000, 0x0001; next pc=0x0002.
REQ-038 instr_ready=0 for 5 cycles in S_OUT -> valid and bundle held constant; single acceptance; no skipped or duplicated instruction.
REQ-039 branch_valid=1, target=0x0200, during S_IMM, and separately concurrently with an accepted S_OUT handshake -> partial bundle dropped, next instr_pc=0x0200.
REQ-040 Reset pulsed in S_IMM, then fetch_en=0 for 3 cycles -> outputs zero, no valid; after fetch_en=1, first bundle instr_pc=RESET_PC.
